// File: rtl/reg_salida_estable_pkg.sv
// Shared definitions for the output dwell stage and its input-side debouncer sibling.
// State encoding, default dwell width and state-decoding helpers.
package reg_salida_estable_pkg;

  localparam int N_DEF = 21;

  typedef enum logic [1:0] {
    BAJO      = 2'b00,
    SOST_ALTO = 2'b01,
    ALTO      = 2'b10,
    SOST_BAJO = 2'b11
  } estado_t;

  function automatic logic nivel_de(input estado_t e);
    return (e == SOST_ALTO) || (e == ALTO);
  endfunction

  function automatic logic en_permanencia(input estado_t e);
    return (e == SOST_ALTO) || (e == SOST_BAJO);
  endfunction

endpackage

// File: rtl/reg_salida_estable_contador.sv
// contador_permanencia: N-bit dwell counter, clear has priority over count enable.
// tc_o flags the last cycle of a 2^N-cycle dwell.
module contador_permanencia
  import reg_salida_estable_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [N-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (clr_i)     cuenta_d = '0;
    else if (en_i) cuenta_d = cuenta_q + N'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cuenta_q <= '0;
    else        cuenta_q <= cuenta_d;
  end

  assign tc_o = &cuenta_q;

endmodule

// File: rtl/reg_salida_estable.sv
// Drives a physical output so every level change is held for at least 2^N cycles,
// with a one-deep latest-wins buffer for requests arriving mid-dwell.
module reg_salida_estable
  import reg_salida_estable_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic dato,
  input  logic dato_valido,
  output logic salida,
  output logic ocupado,
  output logic dato_enviado,
  output logic sobrescrito
);

  estado_t estado_q, estado_d;
  logic    buf_v_q, buf_v_d;
  logic    buf_dato_q, buf_dato_d;
  logic    env_pend_q, env_pend_d;
  logic    salida_q, ocupado_q, env_q, sob_q;
  logic    env_d, sob_d;
  logic    req_v, req_dato, saliendo;
  logic    cnt_clr, cnt_tc;

  contador_permanencia #(.N(N)) u_contador (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (ocupado_q),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    estado_d   = estado_q;
    buf_v_d    = buf_v_q;
    buf_dato_d = buf_dato_q;
    env_d      = env_pend_q;
    env_pend_d = 1'b0;
    sob_d      = 1'b0;
    cnt_clr    = 1'b0;
    req_v      = 1'b0;
    req_dato   = 1'b0;
    saliendo   = 1'b0;

    case (estado_q)
      BAJO, ALTO: begin
        req_v    = dato_valido;
        req_dato = dato;
      end
      default: begin
        if (cnt_tc) begin
          saliendo = 1'b1;
          env_d    = 1'b1;
          estado_d = salida_q ? ALTO : BAJO;
          buf_v_d  = 1'b0;
          // A fresh strobe on the exit edge outranks whatever was buffered
          if (dato_valido) begin
            req_v    = 1'b1;
            req_dato = dato;
            sob_d    = buf_v_q;
          end else begin
            req_v    = buf_v_q;
            req_dato = buf_dato_q;
          end
        end else if (dato_valido) begin
          buf_v_d    = 1'b1;
          buf_dato_d = dato;
          sob_d      = buf_v_q;
        end
      end
    endcase

    if (req_v) begin
      if (req_dato != salida_q) begin
        estado_d = req_dato ? SOST_ALTO : SOST_BAJO;
        cnt_clr  = 1'b1;
      end else if (saliendo) begin
        // Dwell completion already owns this cycle's pulse; acknowledge next cycle
        env_pend_d = 1'b1;
      end else begin
        env_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= BAJO;
      buf_v_q    <= 1'b0;
      env_pend_q <= 1'b0;
      salida_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      env_q      <= 1'b0;
      sob_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      buf_v_q    <= buf_v_d;
      env_pend_q <= env_pend_d;
      salida_q   <= nivel_de(estado_d);
      ocupado_q  <= en_permanencia(estado_d);
      env_q      <= env_d;
      sob_q      <= sob_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_dato_q <= buf_dato_d;
  end

  assign salida       = salida_q;
  assign ocupado      = ocupado_q;
  assign dato_enviado = env_q;
  assign sobrescrito  = sob_q;

endmodule

// File: tb/tb_reg_salida_estable.sv
// Directed bench for reg_salida_estable with N=4 (16-cycle dwell).
// Outputs observed as {salida, ocupado, dato_enviado, sobrescrito}, 1 time unit after each rising edge.
module tb_reg_salida_estable;

  logic clk, reset, dato, dato_valido;
  logic salida, ocupado, dato_enviado, sobrescrito;
  int   chequeos = 0;
  int   errores  = 0;

  reg_salida_estable #(.N(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .dato         (dato),
    .dato_valido  (dato_valido),
    .salida       (salida),
    .ocupado      (ocupado),
    .dato_enviado (dato_enviado),
    .sobrescrito  (sobrescrito)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {salida, ocupado, dato_enviado, sobrescrito};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic d);
    dato        = d;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    chequeos++;
    if (obs() !== 4'b0000) begin
      errores++; $display("FAIL reset_held: got %b expected 0000", obs());
    end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chequeos++;
      if (obs() !== 4'b0000) begin
        errores++; $display("FAIL idle_after_reset cyc %0d: got %b expected 0000", i, obs());
      end
    end
  endtask

  task automatic test_mismo_nivel();
    strobe(1'b0);
    chequeos++;
    if (obs() !== 4'b0010) begin
      errores++; $display("FAIL same_level_ack: got %b expected 0010", obs());
    end
    tick();
    chequeos++;
    if (obs() !== 4'b0000) begin
      errores++; $display("FAIL same_level_after: got %b expected 0000", obs());
    end
  endtask

  // Full dwell from the opposite level to level d
  task automatic test_cambio(input logic d);
    strobe(d);
    chequeos++;
    if (obs() !== {d, 3'b100}) begin
      errores++; $display("FAIL change_start_%0d: got %b expected %b", d, obs(), {d, 3'b100});
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      chequeos++;
      if (obs() !== {d, 3'b100}) begin
        errores++; $display("FAIL change_dwell_%0d cyc %0d: got %b expected %b", d, i, obs(), {d, 3'b100});
      end
    end
    tick();
    chequeos++;
    if (obs() !== {d, 3'b010}) begin
      errores++; $display("FAIL change_done_%0d: got %b expected %b", d, obs(), {d, 3'b010});
    end
    tick();
    chequeos++;
    if (obs() !== {d, 3'b000}) begin
      errores++; $display("FAIL change_idle_%0d: got %b expected %b", d, obs(), {d, 3'b000});
    end
  endtask

  task automatic test_sobrescrito();
    strobe(1'b1);                 // edge k
    tick();                       // k+1
    strobe(1'b0);                 // k+2, buffered
    chequeos++;
    if (obs() !== 4'b1100) begin
      errores++; $display("FAIL ovw_first_buf: got %b expected 1100", obs());
    end
    tick();                       // k+3
    strobe(1'b1);                 // k+4, overwrites
    chequeos++;
    if (obs() !== 4'b1101) begin
      errores++; $display("FAIL ovw_pulse: got %b expected 1101", obs());
    end
    for (int i = 5; i < 16; i++) begin
      tick();
      chequeos++;
      if (obs() !== 4'b1100) begin
        errores++; $display("FAIL ovw_dwell cyc %0d: got %b expected 1100", i, obs());
      end
    end
    tick();                       // k+16
    chequeos++;
    if (obs() !== 4'b1010) begin
      errores++; $display("FAIL ovw_exit: got %b expected 1010", obs());
    end
    tick();
    chequeos++;
    if (obs() !== 4'b1010) begin
      errores++; $display("FAIL ovw_second_ack: got %b expected 1010", obs());
    end
    tick();
    chequeos++;
    if (obs() !== 4'b1000) begin
      errores++; $display("FAIL ovw_idle: got %b expected 1000", obs());
    end
  endtask

  task automatic test_buffer_cambio();
    strobe(1'b1);                 // k
    tick(); tick();               // k+1, k+2
    strobe(1'b0);                 // k+3
    chequeos++;
    if (obs() !== 4'b1100) begin
      errores++; $display("FAIL buf_store: got %b expected 1100", obs());
    end
    repeat (12) tick();           // k+15
    tick();                       // k+16
    chequeos++;
    if (obs() !== 4'b0110) begin
      errores++; $display("FAIL buf_exit: got %b expected 0110", obs());
    end
    for (int i = 17; i < 32; i++) begin
      tick();
      chequeos++;
      if (obs() !== 4'b0100) begin
        errores++; $display("FAIL buf_dwell2 cyc %0d: got %b expected 0100", i, obs());
      end
    end
    tick();                       // k+32
    chequeos++;
    if (obs() !== 4'b0010) begin
      errores++; $display("FAIL buf_done2: got %b expected 0010", obs());
    end
    tick();
    chequeos++;
    if (obs() !== 4'b0000) begin
      errores++; $display("FAIL buf_idle: got %b expected 0000", obs());
    end
  endtask

  task automatic test_back_to_back();
    strobe(1'b1);                 // k
    tick();                       // k+1
    strobe(1'b0);                 // k+2, buffered 0
    repeat (13) tick();           // k+15
    strobe(1'b1);                 // k+16, exit edge: wins over buffer
    chequeos++;
    if (obs() !== 4'b1011) begin
      errores++; $display("FAIL b2b_exit: got %b expected 1011", obs());
    end
    tick();
    chequeos++;
    if (obs() !== 4'b1010) begin
      errores++; $display("FAIL b2b_second_ack: got %b expected 1010", obs());
    end
    tick();
    chequeos++;
    if (obs() !== 4'b1000) begin
      errores++; $display("FAIL b2b_idle: got %b expected 1000", obs());
    end
  endtask

  task automatic test_reset_mid_dwell();
    strobe(1'b1);                 // k
    tick(); tick();               // k+2
    strobe(1'b0);                 // k+3, pending
    repeat (5) tick();            // k+8
    reset = 1'b0;
    #1;
    chequeos++;
    if (obs() !== 4'b0000) begin
      errores++; $display("FAIL rst_async: got %b expected 0000", obs());
    end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      chequeos++;
      if (obs() !== 4'b0000) begin
        errores++; $display("FAIL rst_after cyc %0d: got %b expected 0000", i, obs());
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    dato        = 1'b0;
    dato_valido = 1'b0;
    test_reset();
    test_mismo_nivel();
    test_cambio(1'b1);
    test_cambio(1'b0);
    test_sobrescrito();
    test_cambio(1'b0);
    test_buffer_cambio();
    test_back_to_back();
    test_cambio(1'b0);
    test_reset_mid_dwell();
    $display("Simulation finished: %0d checks, %0d errors", chequeos, errores);
    $finish;
  end

endmodule
